// File: rtl/gen_shift_pkg.sv
// -----------------------------------------------------------------------------
// gen_shift_pkg
// Shared types and constants for the gen_shift target (responder) block.
//   gst_state_t   : frame FSM states (IDLE, LOAD, SHIFT)
//   GS_BYTE_BITS  : bits per serial byte
//   GS_CNT_W      : width of the in-byte bit counter
//   GS_IDX_*      : bit positions of each pin in the synchroniser bus
// -----------------------------------------------------------------------------
package gen_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } gst_state_t;

    localparam int GS_BYTE_BITS = 8;
    localparam int GS_CNT_W     = $clog2(GS_BYTE_BITS);

    // Pin order on the 4-bit synchroniser bus.
    localparam int GS_IDX_SCLK = 0;
    localparam int GS_IDX_DIN  = 1;
    localparam int GS_IDX_AUX  = 2;
    localparam int GS_IDX_CS   = 3;
    localparam int GS_SYNC_W   = 4;

endpackage

// File: rtl/gen_shift_sync.sv
// -----------------------------------------------------------------------------
// gen_shift_sync
// Multi-flop synchroniser followed by one edge-detect flop, per bit of a bus.
//   clk, rst   : system clock, asynchronous active-high reset
//   async_i    : asynchronous pin levels
//   level_o    : synchronised level (output of the last sync stage)
//   rise_o     : one-clk pulse, level went 0 -> 1
//   fall_o     : one-clk pulse, level went 1 -> 0
// RESET_VAL sets the idle level each bit reports out of reset so that no
// spurious edge or select is seen when reset is released.
// -----------------------------------------------------------------------------
module gen_shift_sync #(
    parameter int               WIDTH     = 4,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the value
            // its predecessor held before this edge, giving a true shift chain.
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/gen_shift_target.sv
// -----------------------------------------------------------------------------
// gen_shift_target
// Responder end of the gen_shift byte-serial link. Oversamples SCLK/DIN/AUX/
// CS_B, deserialises DIN and AUX LSB-first on SCLK rise, serialises DOUT
// LSB-first (next bit presented after SCLK fall).
//   clk, rst        : system clock, asynchronous active-high reset
//   sclk_i, din_i,
//   aux_i, cs_b_i   : asynchronous link pins from the master
//   dout_o, dout_t  : target data out and its tristate (1 = released)
//   rx_data_o/aux_o : received byte pair, bit0 = first bit shifted
//   rx_nbits_o      : bits received minus 1
//   rx_valid_o/ready_i : rx holding register stream
//   tx_data_i/valid_i/ready_o : tx holding register stream
//   overrun_o, underrun_o : sticky error flags, cleared by clear_i
// Master prescale must be >= 1 (each SCLK phase >= 2 clk cycles).
// -----------------------------------------------------------------------------
module gen_shift_target
    import gen_shift_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] TX_IDLE     = 8'hFF,
    parameter logic       CS_ACTIVE   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       din_i,
    input  logic       aux_i,
    input  logic       cs_b_i,
    output logic       dout_o,
    output logic       dout_t,
    output logic [7:0] rx_data_o,
    output logic [7:0] rx_aux_o,
    output logic [2:0] rx_nbits_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       overrun_o,
    output logic       underrun_o,
    input  logic       clear_i
);

    // ------------------------------------------------------------------ sync
    localparam logic [GS_SYNC_W-1:0] SYNC_RESET = {~CS_ACTIVE, 3'b000};

    logic [GS_SYNC_W-1:0] pins;
    logic [GS_SYNC_W-1:0] lvl;
    logic [GS_SYNC_W-1:0] rise;
    logic [GS_SYNC_W-1:0] fall;

    assign pins = {cs_b_i, aux_i, din_i, sclk_i};

    gen_shift_sync #(
        .WIDTH     (GS_SYNC_W),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (SYNC_RESET)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (pins),
        .level_o (lvl),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    logic sclk_rise;
    logic sclk_fall;
    logic din_lvl;
    logic aux_lvl;
    logic selected;
    logic edge_unused;

    assign sclk_rise   = rise[GS_IDX_SCLK];
    assign sclk_fall   = fall[GS_IDX_SCLK];
    assign din_lvl     = lvl[GS_IDX_DIN];
    assign aux_lvl     = lvl[GS_IDX_AUX];
    assign selected    = (lvl[GS_IDX_CS] == CS_ACTIVE);
    // Only SCLK edges drive the FSM; the other edge pulses are not needed.
    assign edge_unused = ^{rise[GS_IDX_CS:GS_IDX_DIN], fall[GS_IDX_CS:GS_IDX_DIN], lvl[GS_IDX_SCLK]};

    // ------------------------------------------------------------- registers
    gst_state_t                  state_q,     state_d;
    logic [GS_CNT_W-1:0]         bit_cnt_q,   bit_cnt_d;
    logic [GS_CNT_W-1:0]         last_bit_q,  last_bit_d;   // index of last sampled bit
    logic                        rise_seen_q, rise_seen_d;  // uncommitted bits pending
    logic                        byte_done_q, byte_done_d;  // full byte committed, wait fall
    logic [GS_BYTE_BITS-1:0]     rx_sh_q,     rx_sh_d;
    logic [GS_BYTE_BITS-1:0]     aux_sh_q,    aux_sh_d;
    logic [GS_BYTE_BITS-1:0]     tx_sh_q,     tx_sh_d;
    logic                        dout_q,      dout_d;
    logic                        dout_t_q,    dout_t_d;
    logic [7:0]                  rx_data_q,   rx_data_d;
    logic [7:0]                  rx_aux_q,    rx_aux_d;
    logic [2:0]                  rx_nbits_q,  rx_nbits_d;
    logic                        rx_valid_q,  rx_valid_d;
    logic [7:0]                  tx_hold_q,   tx_hold_d;
    logic                        tx_ready_q,  tx_ready_d;
    logic                        overrun_q,   overrun_d;
    logic                        underrun_q,  underrun_d;

    // Per-clock events produced by the FSM and consumed by the stream logic.
    logic                        commit;
    logic [2:0]                  commit_nbits;
    logic                        consume;
    logic [GS_BYTE_BITS-1:0]     load_byte;
    logic                        pop;
    logic                        tx_load;
    logic                        overrun_set;
    logic                        underrun_set;

    assign pop     = rx_valid_q & rx_ready_i;
    assign tx_load = tx_valid_i & tx_ready_q;
    // An empty holding register means the byte shifted out is the idle pattern.
    assign load_byte = tx_ready_q ? TX_IDLE : tx_hold_q;

    // ------------------------------------------------------------------ FSM
    always_comb begin
        // NOTE: every variable gets a hold/default value before the case so no
        // path leaves it unassigned; that is what keeps this block latch-free.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        last_bit_d   = last_bit_q;
        rise_seen_d  = rise_seen_q;
        byte_done_d  = byte_done_q;
        rx_sh_d      = rx_sh_q;
        aux_sh_d     = aux_sh_q;
        tx_sh_d      = tx_sh_q;
        dout_d       = dout_q;
        dout_t_d     = dout_t_q;
        commit       = 1'b0;
        commit_nbits = '0;
        consume      = 1'b0;

        unique case (state_q)
            IDLE: begin
                dout_t_d = 1'b1;
                if (selected) state_d = LOAD;
            end

            LOAD: begin
                if (!selected) begin
                    state_d  = IDLE;
                    dout_t_d = 1'b1;
                end else begin
                    consume     = 1'b1;
                    tx_sh_d     = load_byte;
                    dout_d      = load_byte[0];
                    dout_t_d    = 1'b0;
                    bit_cnt_d   = '0;
                    rise_seen_d = 1'b0;
                    byte_done_d = 1'b0;
                    rx_sh_d     = '0;
                    aux_sh_d    = '0;
                    state_d     = SHIFT;
                end
            end

            SHIFT: begin
                // Deselect is checked first so it wins over a same-clock rise.
                if (!selected) begin
                    state_d  = IDLE;
                    dout_t_d = 1'b1;
                    if (rise_seen_q) begin
                        commit       = 1'b1;
                        commit_nbits = last_bit_q;
                    end
                end else if (sclk_rise && !byte_done_q) begin
                    rx_sh_d[bit_cnt_q]  = din_lvl;
                    aux_sh_d[bit_cnt_q] = aux_lvl;
                    last_bit_d          = bit_cnt_q;
                    if (bit_cnt_q == GS_CNT_W'(GS_BYTE_BITS - 1)) begin
                        commit       = 1'b1;
                        commit_nbits = 3'd7;
                        byte_done_d  = 1'b1;
                        rise_seen_d  = 1'b0;
                    end else begin
                        rise_seen_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (byte_done_q) begin
                        state_d = LOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        dout_d    = tx_sh_q[bit_cnt_d];
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                dout_t_d = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------- rx / tx holding
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_aux_d     = rx_aux_q;
        rx_nbits_d   = rx_nbits_q;
        rx_valid_d   = rx_valid_q;
        tx_hold_d    = tx_hold_q;
        tx_ready_d   = tx_ready_q;
        overrun_set  = 1'b0;
        underrun_set = 1'b0;

        // A commit in the same clock as a pop wins; that pop is not an overrun.
        if (commit) begin
            rx_data_d   = rx_sh_d;
            rx_aux_d    = aux_sh_d;
            rx_nbits_d  = commit_nbits;
            rx_valid_d  = 1'b1;
            overrun_set = rx_valid_q & ~pop;
        end else if (pop) begin
            rx_valid_d = 1'b0;
        end

        // A load can only happen while empty, so a same-clock consume has
        // already taken TX_IDLE and the new byte simply stays held.
        if (tx_load) begin
            tx_hold_d  = tx_data_i;
            tx_ready_d = 1'b0;
        end else if (consume && !tx_ready_q) begin
            tx_ready_d = 1'b1;
        end
        underrun_set = consume & tx_ready_q;

        overrun_d  = overrun_set  ? 1'b1 : (clear_i ? 1'b0 : overrun_q);
        underrun_d = underrun_set ? 1'b1 : (clear_i ? 1'b0 : underrun_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            last_bit_q  <= '0;
            rise_seen_q <= 1'b0;
            byte_done_q <= 1'b0;
            rx_sh_q     <= '0;
            aux_sh_q    <= '0;
            tx_sh_q     <= '0;
            dout_q      <= 1'b0;
            dout_t_q    <= 1'b1;
            rx_data_q   <= '0;
            rx_aux_q    <= '0;
            rx_nbits_q  <= '0;
            rx_valid_q  <= 1'b0;
            tx_hold_q   <= '0;
            tx_ready_q  <= 1'b1;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            last_bit_q  <= last_bit_d;
            rise_seen_q <= rise_seen_d;
            byte_done_q <= byte_done_d;
            rx_sh_q     <= rx_sh_d;
            aux_sh_q    <= aux_sh_d;
            tx_sh_q     <= tx_sh_d;
            dout_q      <= dout_d;
            dout_t_q    <= dout_t_d;
            rx_data_q   <= rx_data_d;
            rx_aux_q    <= rx_aux_d;
            rx_nbits_q  <= rx_nbits_d;
            rx_valid_q  <= rx_valid_d;
            tx_hold_q   <= tx_hold_d;
            tx_ready_q  <= tx_ready_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    // --------------------------------------------------------------- outputs
    assign dout_o     = dout_q;
    assign dout_t     = dout_t_q;
    assign rx_data_o  = rx_data_q;
    assign rx_aux_o   = rx_aux_q;
    assign rx_nbits_o = rx_nbits_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_ready_o = tx_ready_q;
    assign overrun_o  = overrun_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_gen_shift_target.sv
// -----------------------------------------------------------------------------
// tb_gen_shift_target
// Directed bench for gen_shift_target. A behavioural link master drives
// SCLK/DIN/AUX/CS_B (phase = prescale+1 clk) and samples DOUT at the end of
// each SCLK high phase. Full-byte frames come from a vector table; overrun,
// partial byte, mid-frame reset and deselected-clock cases are hand-written.
// -----------------------------------------------------------------------------
module tb_gen_shift_target;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       din = 1'b0;
    logic       aux = 1'b0;
    logic       cs_b = 1'b1;
    logic       dout;
    logic       dout_t;
    logic [7:0] rx_data;
    logic [7:0] rx_aux;
    logic [2:0] rx_nbits;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       overrun;
    logic       underrun;
    logic       clear = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gen_shift_target #(
        .SYNC_STAGES (2),
        .TX_IDLE     (8'hFF),
        .CS_ACTIVE   (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk_i     (sclk),
        .din_i      (din),
        .aux_i      (aux),
        .cs_b_i     (cs_b),
        .dout_o     (dout),
        .dout_t     (dout_t),
        .rx_data_o  (rx_data),
        .rx_aux_o   (rx_aux),
        .rx_nbits_o (rx_nbits),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .overrun_o  (overrun),
        .underrun_o (underrun),
        .clear_i    (clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One master frame: nb bits LSB-first, dout sampled at end of each high
    // phase. hold=1 stops right after the last rise with CS still asserted.
    task automatic master_xfer(input int nb, input logic [15:0] d, input logic [15:0] a,
                               input int ph, input bit hold,
                               output logic [15:0] q, output logic uf_mid, output logic dt_mid);
        q      = '0;
        uf_mid = 1'b0;
        dt_mid = 1'b1;
        @(negedge clk);
        cs_b = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            din = d[i];
            aux = a[i];
            repeat (ph) @(negedge clk);
            sclk = 1'b1;
            repeat (ph) @(negedge clk);
            q[i] = dout;
            if (i == 3) begin
                uf_mid = underrun;
                dt_mid = dout_t;
            end
            if (hold && i == nb - 1) return;
            sclk = 1'b0;
        end
        repeat (ph) @(negedge clk);
        cs_b = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_clear_pop();
        @(negedge clk);
        clear    = 1'b1;
        rx_ready = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        rx_ready = 1'b0;
    endtask

    task automatic preload(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    typedef struct {
        bit         pre;
        logic [7:0] tx;
        logic [7:0] din;
        logic [7:0] aux;
        int         ph;
        logic [7:0] exp_dout;
        logic [7:0] exp_rx;
        logic [7:0] exp_aux;
        logic       exp_uf_mid;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q;
        logic        uf_mid;
        logic        dt_mid;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'h0F, 2, 8'hA5, 8'h3C, 8'h0F, 1'b0};
        vecs[1] = '{1'b1, 8'hA5, 8'h3C, 8'h0F, 8, 8'hA5, 8'h3C, 8'h0F, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 8'h96, 8'h69, 2, 8'hFF, 8'h96, 8'h69, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[4] = '{1'b1, 8'hC3, 8'h81, 8'h7E, 3, 8'hC3, 8'h81, 8'h7E, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_dout_t", 32'(dout_t), 32'h1);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_tx_ready", 32'(tx_ready), 32'h1);
        check("rst_flags", 32'({overrun, underrun}), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven full-byte frames.
        for (int v = 0; v < 5; v++) begin
            pulse_clear_pop();
            if (vecs[v].pre) begin
                preload(vecs[v].tx);
                check($sformatf("v%0d_tx_ready_held", v), 32'(tx_ready), 32'h0);
            end
            master_xfer(8, {8'h00, vecs[v].din}, {8'h00, vecs[v].aux}, vecs[v].ph, 1'b0, q, uf_mid, dt_mid);
            check($sformatf("v%0d_master_dout", v), 32'(q[7:0]), 32'(vecs[v].exp_dout));
            check($sformatf("v%0d_rx_data", v), 32'(rx_data), 32'(vecs[v].exp_rx));
            check($sformatf("v%0d_rx_aux", v), 32'(rx_aux), 32'(vecs[v].exp_aux));
            check($sformatf("v%0d_rx_nbits", v), 32'(rx_nbits), 32'h7);
            check($sformatf("v%0d_rx_valid", v), 32'(rx_valid), 32'h1);
            check($sformatf("v%0d_underrun_mid", v), 32'(uf_mid), 32'(vecs[v].exp_uf_mid));
            check($sformatf("v%0d_dout_t_mid", v), 32'(dt_mid), 32'h0);
            check($sformatf("v%0d_dout_t_end", v), 32'(dout_t), 32'h1);
            check($sformatf("v%0d_overrun", v), 32'(overrun), 32'h0);
            check($sformatf("v%0d_tx_ready_end", v), 32'(tx_ready), 32'h1);
        end

        // Back-to-back bytes 01, 80 with rx_ready held low -> overrun.
        pulse_clear_pop();
        master_xfer(16, 16'h8001, 16'h0000, 2, 1'b0, q, uf_mid, dt_mid);
        check("b2b_rx_data", 32'(rx_data), 32'h80);
        check("b2b_rx_valid", 32'(rx_valid), 32'h1);
        check("b2b_overrun", 32'(overrun), 32'h1);
        check("b2b_master_dout", 32'(q), 32'hFFFF);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("b2b_overrun_cleared", 32'(overrun), 32'h0);
        check("b2b_underrun_cleared", 32'(underrun), 32'h0);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("pop_rx_valid", 32'(rx_valid), 32'h0);

        // Partial byte: 3 bits of 8'h05 then deselect.
        master_xfer(3, 16'h0005, 16'h0000, 2, 1'b0, q, uf_mid, dt_mid);
        check("part_rx_bits", 32'(rx_data[2:0]), 32'h5);
        check("part_rx_nbits", 32'(rx_nbits), 32'h2);
        check("part_rx_valid", 32'(rx_valid), 32'h1);
        check("part_dout_t", 32'(dout_t), 32'h1);

        // Reset after the 4th SCLK rise of a frame.
        master_xfer(4, 16'h00FF, 16'h00FF, 2, 1'b1, q, uf_mid, dt_mid);
        check("pre_rst_dout_t", 32'(dout_t), 32'h0);
        rst = 1'b1;
        #1;
        check("mid_rst_dout", 32'(dout), 32'h0);
        check("mid_rst_dout_t", 32'(dout_t), 32'h1);
        check("mid_rst_rx", 32'({rx_data, rx_aux, 5'(rx_nbits)}), 32'h0);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'h0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'h1);
        check("mid_rst_flags", 32'({overrun, underrun}), 32'h0);
        @(negedge clk);
        sclk = 1'b0;
        cs_b = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        preload(8'h3C);
        master_xfer(8, 16'h005A, 16'h00A5, 2, 1'b0, q, uf_mid, dt_mid);
        check("post_rst_rx_data", 32'(rx_data), 32'h5A);
        check("post_rst_rx_aux", 32'(rx_aux), 32'hA5);
        check("post_rst_rx_nbits", 32'(rx_nbits), 32'h7);
        check("post_rst_master_dout", 32'(q[7:0]), 32'h3C);

        // SCLK toggling while deselected is ignored.
        pulse_clear_pop();
        for (int i = 0; i < 6; i++) begin
            din = i[0];
            repeat (3) @(negedge clk);
            sclk = ~sclk;
        end
        repeat (6) @(negedge clk);
        check("desel_rx_valid", 32'(rx_valid), 32'h0);
        check("desel_dout_t", 32'(dout_t), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
